bus_transfer_sequencer: RTL and testbench

- Drives the datapath bus from the control side. It owns the 5-bit select that picks the bus source, and the one-hot load enables that capture the bus into a destination register.
- Accepts queued (source, destination) transfer requests over a valid/ready interface and buffers them in a small FIFO.
- Executes each transfer as a two-phase sequence: first it drives the select, then it pulses the destination load.
- Sits between the control unit and the bus multiplexer / register-enable fabric.

---
 rtl/bus_transfer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queues (src,dst) bus transfers and runs each one as DRIVE (select only) then LOAD (one-hot load pulse).
// Latency: a request pushed into an empty FIFO at edge N drives bus_sel from N+1 and pulses dst_load from N+2; sustained rate 1 per 2 cycles.
// Backpressure: req_ready = FIFO not full; hold stretches DRIVE. Define BUS_TRANSFER_STATS_EN to add xfer_count/err_count outputs.
module bus_transfer_sequencer #(
  parameter int         DEPTH     = 4,
  parameter int         NUM_CODES = 24,
  parameter logic [4:0] PARK_SEL  = 5'd31
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4:0]             req_src,
  input  logic [4:0]             req_dst,
  input  logic                   hold,
  output logic [4:0]             bus_sel,
  output logic [NUM_CODES-1:0]   dst_load,
  output logic                   xfer_done,
  output logic                   busy,
  output logic                   err_code,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef BUS_TRANSFER_STATS_EN
  ,
  output logic [15:0]            xfer_count,
  output logic [7:0]             err_count
`endif
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [5:0]  NC       = 6'(NUM_CODES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // request FIFO storage and pointers
  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // sequencer state and registered outputs
  state_t               state_q, state_d;
  logic [4:0]           src_q, src_d;
  logic [4:0]           dst_q, dst_d;
  logic [4:0]           bus_sel_q, bus_sel_d;
  logic [NUM_CODES-1:0] dst_load_q, dst_load_d;
  logic                 xfer_done_q, xfer_done_d;
  logic                 err_q, err_d;

  logic       push, pop, empty, head_legal;
  logic [4:0] head_src, head_dst;

  // FIFO status; ready comes from the pre-edge count only
  assign req_ready  = (count_q != FULL_CNT);
  assign push       = req_valid && req_ready;
  assign empty      = (count_q == '0);
  assign head_src   = mem_q[rd_ptr_q][9:5];
  assign head_dst   = mem_q[rd_ptr_q][4:0];
  assign head_legal = ({1'b0, head_src} < NC) && ({1'b0, head_dst} < NC);

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // FIFO payload write; contents need no reset since occupancy gates reads
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_src, req_dst};
    end
  end

  // next-state logic: pop in IDLE or LOAD, discard illegal heads, outputs decoded from next state
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        state_d = IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            src_d   = head_src;
            dst_d   = head_dst;
            state_d = DRIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (!hold) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    bus_sel_d   = (state_d == IDLE) ? PARK_SEL : src_d;
    xfer_done_d = (state_d == LOAD);
    dst_load_d  = '0;
    for (int i = 0; i < NUM_CODES; i++) begin
      dst_load_d[i] = (state_d == LOAD) && (dst_d == 5'(i));
    end
  end

  // single state register: FSM, latched transfer, FIFO pointers and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      err_q       <= 1'b0;
      bus_sel_q   <= PARK_SEL;
      dst_load_q  <= '0;
      xfer_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      err_q       <= err_d;
      bus_sel_q   <= bus_sel_d;
      dst_load_q  <= dst_load_d;
      xfer_done_q <= xfer_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign bus_sel    = bus_sel_q;
  assign dst_load   = dst_load_q;
  assign xfer_done  = xfer_done_q;
  assign err_code   = err_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || !empty;

`ifdef BUS_TRANSFER_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;
  logic [7:0]  err_count_q, err_count_d;

  // transfer counter wraps, error counter saturates; both move on the same edge as the event they count
  always_comb begin
    xfer_count_d = xfer_done_d ? xfer_count_q + 16'd1 : xfer_count_q;
    err_count_d  = err_count_q;
    if (pop && !head_legal && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // statistics registers
  always_ff @(posedge clock) begin
    if (clear) begin
      xfer_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: directed scenarios with literal expectations, then random traffic.
// A queue-based model predicts every output each cycle; a single negedge process compares.
// Compile with BUS_TRANSFER_STATS_EN defined to also check the statistics counters.
module tb_bus_transfer_sequencer;

  localparam int DEPTH     = 4;
  localparam int NUM_CODES = 24;

  logic                 clock = 1'b0;
  logic                 clear, req_valid, req_ready, hold;
  logic [4:0]           req_src, req_dst, bus_sel;
  logic [NUM_CODES-1:0] dst_load;
  logic                 xfer_done, busy, err_code;
  logic [2:0]           fifo_count;
`ifdef BUS_TRANSFER_STATS_EN
  logic [15:0]          xfer_count;
  logic [7:0]           err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bus_transfer_sequencer #(
    .DEPTH(DEPTH), .NUM_CODES(NUM_CODES), .PARK_SEL(5'd31)
  ) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .hold(hold),
    .bus_sel(bus_sel), .dst_load(dst_load), .xfer_done(xfer_done),
    .busy(busy), .err_code(err_code), .fifo_count(fifo_count)
`ifdef BUS_TRANSFER_STATS_EN
    , .xfer_count(xfer_count), .err_count(err_count)
`endif
  );

  // Behavioural model: pending queue plus the transfer currently owning the bus.
  logic [9:0] mq[$];
  bit         m_active;     // a transfer owns the bus (select driven)
  bit         m_loading;    // that transfer is in its load cycle
  logic [4:0] m_src, m_dst;
  bit         m_err;
  int         m_xfers, m_errs;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs presented to that edge.
  function automatic void model_edge();
    bit         was_room;
    logic [9:0] e;
    if (clear) begin
      mq.delete();
      m_active = 0; m_loading = 0; m_err = 0;
      m_xfers = 0; m_errs = 0;
      return;
    end
    was_room = (mq.size() < DEPTH);
    if (m_active && !m_loading) begin
      if (!hold) begin
        m_loading = 1;
        m_xfers = (m_xfers + 1) % 65536;
      end
    end else begin
      m_active = 0; m_loading = 0;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (int'(e[9:5]) < NUM_CODES && int'(e[4:0]) < NUM_CODES) begin
          m_active = 1; m_src = e[9:5]; m_dst = e[4:0];
        end else begin
          m_err = 1;
          if (m_errs < 255) m_errs++;
        end
      end
    end
    if (req_valid && was_room) mq.push_back({req_src, req_dst});
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("bus_sel",    32'(bus_sel),    m_active ? 32'(m_src) : 32'd31);
      chk("dst_load",   32'(dst_load),   m_loading ? (32'd1 << m_dst) : 32'd0);
      chk("xfer_done",  32'(xfer_done),  32'(m_loading));
      chk("busy",       32'(busy),       32'(m_active || mq.size() > 0));
      chk("err_code",   32'(err_code),   32'(m_err));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("req_ready",  32'(req_ready),  32'(mq.size() < DEPTH));
`ifdef BUS_TRANSFER_STATS_EN
      chk("xfer_count", 32'(xfer_count), 32'(m_xfers));
      chk("err_count",  32'(err_count),  32'(m_errs));
`endif
    end
  end

  // One clock cycle with the given inputs; returns just after the following negedge.
  task automatic step(input bit v, input int s, input int d, input bit h, input bit c);
    req_valid = v; req_src = 5'(s); req_dst = 5'(d); hold = h; clear = c;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int pulse_idx[$];
    int pulse_val[$];
    int exp_d[5];
    int run3;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_bus_sel",    32'(bus_sel),    32'd31);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_dst_load",   32'(dst_load),   32'd0);
    chk("rst_err_code",   32'(err_code),   32'd0);

    // single transfer latency
    step(1, 20, 21, 0, 0);
    chk("t1_push_park", 32'(bus_sel), 32'd31);
    step(0, 0, 0, 0, 0);
    chk("t1_drive_sel",  32'(bus_sel),  32'd20);
    chk("t1_drive_load", 32'(dst_load), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("t1_load_sel",  32'(bus_sel),   32'd20);
    chk("t1_load_dst",  32'(dst_load),  32'h0020_0000);
    chk("t1_load_done", 32'(xfer_done), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("t1_end_sel",  32'(bus_sel), 32'd31);
    chk("t1_end_busy", 32'(busy),    32'd0);

    // fill the FIFO while the bus is held, then drain back-to-back
    step(1, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 4, 5, 1, 0);
    step(1, 6, 7, 1, 0);
    step(1, 8, 9, 1, 0);
    step(1, 10, 11, 1, 0);
    chk("t2_full_ready", 32'(req_ready),  32'd0);
    chk("t2_full_count", 32'(fifo_count), 32'd4);
    step(1, 12, 13, 1, 0);
    chk("t2_ignored_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      if (xfer_done) begin
        pulse_idx.push_back(i);
        pulse_val.push_back(int'(dst_load));
      end
    end
    exp_d = '{2, 5, 7, 9, 11};
    chk("t2_pulses", 32'(pulse_idx.size()), 32'd5);
    for (int k = 0; k < 5 && k < pulse_idx.size(); k++) begin
      chk("t2_order", 32'(pulse_val[k]), 32'd1 << exp_d[k]);
      if (k > 0) chk("t2_spacing", 32'(pulse_idx[k] - pulse_idx[k-1]), 32'd2);
    end

    // hold stretches DRIVE
    idle(1);
    step(1, 3, 7, 0, 0);
    run3 = 0;
    step(0, 0, 0, 0, 0);
    if (bus_sel == 5'd3 && dst_load == '0) run3++;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      if (bus_sel == 5'd3 && dst_load == '0) run3++;
    end
    chk("t3_drive_cycles", 32'(run3), 32'd4);
    step(0, 0, 0, 0, 0);
    chk("t3_load", 32'(dst_load), 32'h80);
    chk("t3_sel",  32'(bus_sel),  32'd3);
    idle(2);

    // illegal source is discarded, error is sticky
    step(1, 25, 2, 0, 0);
    step(1, 1, 2, 0, 0);
    chk("t4_err",     32'(err_code), 32'd1);
    chk("t4_no_load", 32'(dst_load), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("t4_sel", 32'(bus_sel), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("t4_load",       32'(dst_load), 32'h4);
    chk("t4_err_sticky", 32'(err_code), 32'd1);
    idle(2);

    // clear during LOAD with entries queued
    step(1, 19, 0, 0, 0);
    step(1, 2, 3, 0, 0);
    step(1, 4, 5, 0, 0);
    chk("t5_in_load", 32'(dst_load),   32'h1);
    chk("t5_queued",  32'(fifo_count), 32'd2);
    step(0, 0, 0, 0, 1);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_load",  32'(dst_load),   32'd0);
    chk("t5_sel",   32'(bus_sel),    32'd31);
    chk("t5_err",   32'(err_code),   32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int s, d;
      s = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
      step($urandom_range(0, 99) < 60, s, d, $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
